// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, frame constants and the default idle timeout.
package boot_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_CSUM  = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   localparam int unsigned BYTES_PER_WORD  = 2;
   localparam int unsigned DEFAULT_TIMEOUT = 1024;

   // True while a frame is open and the loader is accepting bytes.
   function automatic logic in_frame(input state_t s);
      return (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/boot_timer.sv
// Idle-cycle counter: counts while run is high and clear is low;
// expired flags the cycle where TIMEOUT idle cycles complete.
module boot_timer
   import boot_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count_q, count_d;

   assign expired = run && !clear && (count_q == CW'(TIMEOUT - 1));

   always_comb begin
      count_d = count_q;
      if (clear || !run || expired) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a LEN/payload/CSUM byte frame into instruction memory as 16-bit
// words and holds the CPU in reset until the image checksum verifies.
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_WORDS = 128,
   parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [7:0]        words_loaded
);

   state_t            state_q, state_d;
   logic              rx_ready_q, rx_ready_d;
   logic              im_we_q, im_we_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [7:0]        words_q, words_d;
   logic [7:0]        n_q, n_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        csum_q, csum_d;

   logic xfer;
   logic expired;

   assign xfer = rx_valid && rx_ready_q;

   boot_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .run     (in_frame(state_q)),
      .clear   (xfer),
      .expired (expired)
   );

   always_comb begin
      state_d    = state_q;
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      words_d    = words_q;
      n_d        = n_q;
      hi_d       = hi_q;
      csum_d     = csum_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN;
               words_d = '0;
               csum_d  = '0;
            end
         end
         S_LEN: begin
            if (xfer) begin
               if ((rx_data == 8'd0) || (32'(rx_data) > MAX_WORDS)) begin
                  state_d = S_ERROR;
               end else begin
                  n_d     = rx_data;
                  words_d = '0;
                  state_d = S_HI;
               end
            end
         end
         S_HI: begin
            if (xfer) begin
               hi_d    = rx_data;
               csum_d  = csum_q ^ rx_data;
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (xfer) begin
               csum_d     = csum_q ^ rx_data;
               im_we_d    = 1'b1;
               im_addr_d  = ADDR_W'(BYTES_PER_WORD * words_q);
               im_wdata_d = DATA_W'({hi_q, rx_data});
               words_d    = words_q + 8'd1;
               state_d    = (({1'b0, words_q} + 9'd1) < {1'b0, n_q}) ? S_HI : S_CSUM;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // expired is only ever raised in a frame state with no transfer pending
      if (expired) begin
         state_d = S_ERROR;
      end

      rx_ready_d  = in_frame(state_d);
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERROR);
      cpu_reset_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rx_ready_q  <= 1'b0;
         im_we_q     <= 1'b0;
         im_addr_q   <= '0;
         im_wdata_q  <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         words_q     <= '0;
         n_q         <= '0;
         hi_q        <= '0;
         csum_q      <= '0;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         im_we_q     <= im_we_d;
         im_addr_q   <= im_addr_d;
         im_wdata_q  <= im_wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
         words_q     <= words_d;
         n_q         <= n_d;
         hi_q        <= hi_d;
         csum_q      <= csum_d;
      end
   end

   assign rx_ready     = rx_ready_q;
   assign im_we        = im_we_q;
   assign im_addr      = im_addr_q;
   assign im_wdata     = im_wdata_q;
   assign cpu_reset    = cpu_reset_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad frames, LEN limits,
// idle timeout, gapped delivery with stray starts, and mid-frame reset.
module tb_imem_boot_loader;

   localparam int unsigned TO = 32;

   logic        clk = 1'b0;
   logic        reset, start, rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready, im_we, cpu_reset, done, error;
   logic [7:0]  im_addr, words_loaded;
   logic [15:0] im_wdata;

   int total = 0;
   int bad   = 0;

   // write log, owned by the monitor process only
   logic [7:0]  wr_addr [0:63];
   logic [15:0] wr_data [0:63];
   int          wr_n      = 0;
   int          pulse_err = 0;
   logic        prev_we   = 1'b0;

   logic [7:0] frame1 [0:7];
   int base;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .ADDR_W    (8),
      .DATA_W    (16),
      .MAX_WORDS (128),
      .TIMEOUT   (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_reset    (cpu_reset),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always @(negedge clk) begin
      if (im_we && wr_n < 64) begin
         wr_addr[wr_n] = im_addr;
         wr_data[wr_n] = im_wdata;
         wr_n = wr_n + 1;
      end
      if (im_we && prev_we) pulse_err = pulse_err + 1;
      prev_we = im_we;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      w = 0;
      while (!rx_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic check_frame1_writes(input string tag, input int b0);
      chk({tag, "_nwr"}, 32'(wr_n - b0), 32'd3);
      chk({tag, "_a0"}, 32'(wr_addr[b0]),   32'h00);
      chk({tag, "_d0"}, 32'(wr_data[b0]),   32'h1234);
      chk({tag, "_a1"}, 32'(wr_addr[b0+1]), 32'h02);
      chk({tag, "_d1"}, 32'(wr_data[b0+1]), 32'h5678);
      chk({tag, "_a2"}, 32'(wr_addr[b0+2]), 32'h04);
      chk({tag, "_d2"}, 32'(wr_data[b0+2]), 32'h9ABC);
   endtask

   initial begin
      // 12^34^56^78^9A^BC = 2E
      frame1[0] = 8'h03; frame1[1] = 8'h12; frame1[2] = 8'h34; frame1[3] = 8'h56;
      frame1[4] = 8'h78; frame1[5] = 8'h9A; frame1[6] = 8'hBC; frame1[7] = 8'h2E;

      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_rx_ready",  32'(rx_ready),  32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_error",     32'(error),     32'd0);
      chk("rst_im_we",     32'(im_we),     32'd0);
      chk("rst_words",     32'(words_loaded), 32'd0);
      chk("rst_im_addr",   32'(im_addr),   32'd0);
      chk("rst_im_wdata",  32'(im_wdata),  32'd0);

      // rx_valid in IDLE is not accepted
      rx_valid = 1'b1; rx_data = 8'h03;
      repeat (3) @(negedge clk);
      chk("idle_no_ready", 32'(rx_ready), 32'd0);
      rx_valid = 1'b0;

      // good frame with per-word latency checks
      base = wr_n;
      pulse_start();
      chk("t1_ready_after_start", 32'(rx_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         send_byte(frame1[i]);
         if (i == 2 || i == 4 || i == 6) begin
            chk("t1_we_latency", 32'(im_we), 32'd1);
            chk("t1_addr_latency", 32'(im_addr), 32'(i - 2));
         end
         if (i == 7) begin
            chk("t1_done", 32'(done), 32'd1);
            chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
         end
      end
      @(negedge clk);
      chk("t1_error", 32'(error), 32'd0);
      chk("t1_words", 32'(words_loaded), 32'd3);
      chk("t1_ready_off", 32'(rx_ready), 32'd0);
      chk("t1_addr_hold", 32'(im_addr), 32'h04);
      chk("t1_data_hold", 32'(im_wdata), 32'h9ABC);
      check_frame1_writes("t1", base);

      // bad checksum, restarted from DONE
      base = wr_n;
      pulse_start();
      chk("t2_done_cleared", 32'(done), 32'd0);
      chk("t2_cpu_reset_set", 32'(cpu_reset), 32'd1);
      chk("t2_words_cleared", 32'(words_loaded), 32'd0);
      for (int i = 0; i < 7; i++) send_byte(frame1[i]);
      send_byte(8'h85);
      chk("t2_error", 32'(error), 32'd1);
      chk("t2_done", 32'(done), 32'd0);
      chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t2_words", 32'(words_loaded), 32'd3);
      check_frame1_writes("t2", base);

      // LEN out of range
      base = wr_n;
      pulse_start();
      send_byte(8'h00);
      chk("t3_len0_error", 32'(error), 32'd1);
      chk("t3_len0_ready", 32'(rx_ready), 32'd0);
      pulse_start();
      chk("t3_restart_err_clr", 32'(error), 32'd0);
      send_byte(8'h81);
      chk("t3_len81_error", 32'(error), 32'd1);
      chk("t3_len81_ready", 32'(rx_ready), 32'd0);
      rx_valid = 1'b1; rx_data = 8'h55;
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      chk("t3_err_ignores_rx", 32'(words_loaded), 32'd0);
      chk("t3_no_writes", 32'(wr_n - base), 32'd0);

      // idle timeout after one word
      base = wr_n;
      pulse_start();
      send_byte(8'h02);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (TO - 1) @(posedge clk);
      #1;
      chk("t4_not_yet", 32'(error), 32'd0);
      chk("t4_still_ready", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("t4_timeout_error", 32'(error), 32'd1);
      chk("t4_cpu_held", 32'(cpu_reset), 32'd1);
      chk("t4_nwr", 32'(wr_n - base), 32'd1);
      chk("t4_addr", 32'(wr_addr[base]), 32'h00);
      chk("t4_data", 32'(wr_data[base]), 32'hAABB);

      // gapped delivery with stray start pulses inside the frame
      base = wr_n;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         if (i == 2 || i == 5) pulse_start();
         send_byte(frame1[i]);
      end
      @(negedge clk);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_words", 32'(words_loaded), 32'd3);
      check_frame1_writes("t5", base);

      // reset while the LO byte of the second word is on the bus
      base = wr_n;
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(frame1[i]);
      @(negedge clk);
      rx_data = 8'h78; rx_valid = 1'b1; reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0; rx_valid = 1'b0;
      chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t6_rx_ready",  32'(rx_ready),  32'd0);
      chk("t6_im_we",     32'(im_we),     32'd0);
      chk("t6_done",      32'(done),      32'd0);
      chk("t6_error",     32'(error),     32'd0);
      chk("t6_words",     32'(words_loaded), 32'd0);
      chk("t6_im_addr",   32'(im_addr),   32'd0);
      chk("t6_im_wdata",  32'(im_wdata),  32'd0);
      chk("t6_partial_nwr", 32'(wr_n - base), 32'd1);
      base = wr_n;
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(frame1[i]);
      @(negedge clk);
      chk("t6_reload_done", 32'(done), 32'd1);
      chk("t6_reload_cpu", 32'(cpu_reset), 32'd0);
      check_frame1_writes("t6", base);

      chk("we_single_cycle", 32'(pulse_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
